// File: rtl/pipelined_adder.sv
// Pipelined ripple adder: {C_out,S_out} = A_in + B_in + C_in, one WIDTH/STAGES-bit
// slice per stage, with a valid/ready handshake on both sides. WIDTH must be an
// integer multiple of STAGES.
// Optional feature: define PIPELINED_ADDER_OVERFLOW_EN to add the V_out
// signed-overflow flag, which travels with S_out.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out,
  output logic             valid_out,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  output logic             V_out,
`endif
  input  logic             ready_in
);

  localparam int SW = WIDTH / STAGES;

  // One pipeline slot. Operands still to be added (upper slices) and the sum
  // slices already done (lower slices) both move along with the carry.
  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  logic   advance;

  // The whole pipeline moves together. It freezes only when the output
  // holds a result that the consumer has not taken yet.
  assign advance   = !st_q[STAGES-1].v || ready_in;
  assign ready_out = advance;

  // Per-stage slice add. Stage k reads the previous slot, or the ports when k is 0.
  always_comb begin
    logic [WIDTH-1:0] pa, pb, ps;
    logic             pc, pv, cout;
    logic [SW-1:0]    sl;
    int               prev;
    for (int k = 0; k < STAGES; k++) begin
      prev = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        pa = A_in;
        pb = B_in;
        ps = '0;
        pc = C_in;
        pv = valid_in;
      end else begin
        pa = st_q[prev].a;
        pb = st_q[prev].b;
        ps = st_q[prev].s;
        pc = st_q[prev].c;
        pv = st_q[prev].v;
      end
      {cout, sl} = {1'b0, pa[k*SW +: SW]} + {1'b0, pb[k*SW +: SW]} + (SW+1)'(pc);
      st_d[k].v = pv;
      st_d[k].c = cout;
      st_d[k].a = pa;
      st_d[k].b = pb;
      st_d[k].s = ps;
      st_d[k].s[k*SW +: SW] = sl;
    end
  end

  // Stage registers. They are cleared on reset so that in-flight work is dropped.
  // NOTE: every stage register is reset, data included. This makes outputs read 0
  // while reset is held, not only the valid bits.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (advance) begin
      // NOTE: use non-blocking assignment so each stage samples the previous
      // stage's value from before this edge, not the updated one.
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

  assign S_out     = st_q[STAGES-1].s;
  assign C_out     = st_q[STAGES-1].c;
  assign valid_out = st_q[STAGES-1].v;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Overflow is the carry into the MSB XOR the carry out of the MSB. It is
  // formed in the last stage, and the carry into the MSB is recovered from
  // the MSB sum bit.
  always_comb begin
    logic [WIDTH-1:0] pa, pb;
    int               last;
    last  = (STAGES > 1) ? STAGES - 2 : 0;
    pa    = (STAGES > 1) ? st_q[last].a : A_in;
    pb    = (STAGES > 1) ? st_q[last].b : B_in;
    ovf_d = pa[WIDTH-1] ^ pb[WIDTH-1] ^ st_d[STAGES-1].s[WIDTH-1] ^ st_d[STAGES-1].c;
  end

  // The flag register advances in step with the last stage.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)       ovf_q <= 1'b0;
    else if (advance) ovf_q <= ovf_d;
  end

  assign V_out = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4). It runs directed
// steps followed by a randomized valid/ready stream, and every result is checked
// against a slot-level model that uses plain arithmetic sums.
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_in;
  logic [W-1:0] A_in, B_in, S_out;
  logic         C_in, valid_in, ready_out, C_out, valid_out, ready_in;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic         V_out;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .A_in     (A_in),
    .B_in     (B_in),
    .C_in     (C_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .S_out    (S_out),
    .C_out    (C_out),
    .valid_out(valid_out),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    .V_out    (V_out),
`endif
    .ready_in (ready_in)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: one slot per pipeline stage, each holding the expected 33-bit sum.
  bit         m_vld [N];
  logic [W:0] m_res [N];
  bit         m_ovf [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(logic [W-1:0] a, logic [W-1:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  function automatic bit ref_ovf(logic [W-1:0] a, logic [W-1:0] b, logic c);
    longint r;
    r = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 0;
      m_res[i] = '0;
      m_ovf[i] = 0;
    end
  endtask

  // One clock cycle. Inputs must already be set. This task checks the handshake,
  // moves the model forward, and then checks the outputs at the falling edge.
  task automatic tick();
    bit adv, acc;
    #1;
    adv = !m_vld[N-1] || ready_in;
    acc = valid_in && adv;
    chk("ready_out", ready_out, adv);
    @(posedge clk);
    if (adv) begin
      for (int i = N - 1; i > 0; i--) begin
        m_vld[i] = m_vld[i-1];
        m_res[i] = m_res[i-1];
        m_ovf[i] = m_ovf[i-1];
      end
      m_vld[0] = acc;
      m_res[0] = ref_sum(A_in, B_in, C_in);
      m_ovf[0] = ref_ovf(A_in, B_in, C_in);
    end
    @(negedge clk);
    #1;
    chk("valid_out", valid_out, m_vld[N-1]);
    if (m_vld[N-1]) begin
      chk("sum", {C_out, S_out}, m_res[N-1]);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      chk("ovf", V_out, m_ovf[N-1]);
`endif
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    valid_in = v;
    A_in     = a;
    B_in     = b;
    C_in     = c;
  endtask

  logic [W-1:0] exp3 [3];
  logic [W-1:0] seen;
  bit           got;

  initial begin
    rst_in   = 1'b1;
    ready_in = 1'b1;
    drive(0, '0, '0, 0);
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_S", S_out, 32'd0);
    chk("rst_C", C_out, 1'b0);
    chk("rst_ready", ready_out, 1'b1);
    rst_in = 1'b0;

    // A single operation. The result appears 4 cycles later for one cycle.
    drive(1, 32'd15, 32'd49, 1);
    tick();
    drive(0, '0, '0, 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("lat_valid", valid_out, (i == 4));
      if (i == 4) chk("lat_S", {C_out, S_out}, 33'd65);
    end

    // Carry ripples through all four stages.
    drive(1, 32'hFFFF_FFFF, 32'd0, 1);
    tick();
    drive(0, '0, '0, 0);
    repeat (3) tick();
    chk("ripple_S", S_out, 32'd0);
    chk("ripple_C", C_out, 1'b1);

    // Back-to-back transfers produce results on consecutive cycles.
    exp3[0] = 32'd3; exp3[1] = 32'd7; exp3[2] = 32'd11;
    drive(1, 32'd1, 32'd2, 0); tick();
    drive(1, 32'd3, 32'd4, 0); tick();
    drive(1, 32'd5, 32'd6, 0); tick();
    drive(0, '0, '0, 0);
    for (int i = 4; i <= 6; i++) begin
      tick();
      chk("b2b_valid", valid_out, 1'b1);
      chk("b2b_S", S_out, exp3[i-4]);
    end
    tick();

    // Backpressure while 65 is waiting. A pending input must not be taken.
    drive(1, 32'd15, 32'd49, 1);
    tick();
    drive(0, '0, '0, 0);
    repeat (3) tick();
    chk("bp_pre", S_out, 32'd65);
    ready_in = 1'b0;
    drive(1, 32'd100, 32'd200, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_S", S_out, 32'd65);
      chk("bp_hold_v", valid_out, 1'b1);
      chk("bp_ready", ready_out, 1'b0);
    end
    ready_in = 1'b1;
    tick();
    chk("bp_no_dup", valid_out, 1'b0);
    drive(0, '0, '0, 0);
    got = 0;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out && !got) begin
        got  = 1;
        seen = S_out;
      end
    end
    chk("bp_resume_seen", got, 1'b1);
    chk("bp_resume_S", seen, 32'd300);

    // Reset in the middle of an operation discards it.
    drive(1, 32'd15, 32'd49, 0);
    tick();
    drive(0, '0, '0, 0);
    tick();
    tick();
    #2;
    rst_in = 1'b1;
    #1;
    clear_model();
    chk("mid_rst_valid", valid_out, 1'b0);
    chk("mid_rst_S", S_out, 32'd0);
    chk("mid_rst_ready", ready_out, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_valid", valid_out, 1'b0);
      chk("post_rst_out", {C_out, S_out}, 33'd0);
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    drive(1, 32'h7FFF_FFFF, 32'd1, 0); tick();
    drive(1, 32'h8000_0000, 32'h8000_0000, 0); tick();
    drive(0, '0, '0, 0);
    tick(); tick();
    chk("ovf1_S", S_out, 32'h8000_0000);
    chk("ovf1_V", V_out, 1'b1);
    chk("ovf1_C", C_out, 1'b0);
    tick();
    chk("ovf2_S", S_out, 32'd0);
    chk("ovf2_V", V_out, 1'b1);
    chk("ovf2_C", C_out, 1'b1);
    tick();
`endif

    // Randomized stream with random bubbles and random backpressure.
    for (int i = 0; i < 400; i++) begin
      ready_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       drive($urandom_range(0, 3) != 0, 32'hFFFF_FFFF, $urandom_range(0, 1), $urandom_range(0, 1));
        1:       drive($urandom_range(0, 3) != 0, 32'h8000_0000, $urandom, $urandom_range(0, 1));
        default: drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1));
      endcase
      tick();
    end
    ready_in = 1'b1;
    drive(0, '0, '0, 0);
    repeat (N + 2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline stages; WIDTH SHALL be an integer multiple of STAGES, and each slice is WIDTH/STAGES bits.
REQ-003 SHALL have clk_in  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_in  input  1  asynchronous, active-high reset.
REQ-005 SHALL have A_in  input  WIDTH  operand A.
REQ-006 SHALL have B_in  input  WIDTH  operand B.
REQ-007 SHALL have C_in  input  1  carry-in.
REQ-008 SHALL have valid_in  input  1  the operand set is valid this cycle.
REQ-009 SHALL have ready_out  output  1  the block accepts operands this cycle.
REQ-010 SHALL have S_out  output  WIDTH  sum.
REQ-011 SHALL have C_out  output  1  carry-out of the MSB.
REQ-012 SHALL have valid_out  output  1  S_out/C_out hold a valid result.
REQ-013 SHALL have ready_in  input  1  the downstream consumer accepts the result.

Function
REQ-014 SHALL compute {C_out,S_out} = A_in + B_in + C_in modulo 2^(WIDTH+1), with no truncation of the carry.
REQ-015 Stage k (k = 0..STAGES-1) SHALL add slice k of A and B plus the carry registered from stage k-1 (stage 0 uses C_in).
REQ-016 SHALL forward the unprocessed upper operand slices and the completed lower sum slices through the stage registers, so each stage uses one slice-wide carry chain.
REQ-017 Each stage SHALL hold a valid bit; a transfer occurs on a cycle with valid_in=1 and ready_out=1.
REQ-018 ready_out SHALL equal (!valid_out || ready_in); when ready_out=0, all stage registers and valid bits SHALL hold.
REQ-019 When advancing, each stage SHALL take the contents and valid bit of the previous stage; stage 0 SHALL take valid_in.
REQ-020 Latency from an accepted transfer to valid_out=1 SHALL be exactly STAGES cycles with no stalls; each stall cycle SHALL add one cycle.
REQ-021 Throughput SHALL be one operation per cycle while ready_in=1; bubbles (valid_in=0) SHALL propagate as invalid stages.
REQ-022 S_out, C_out and valid_out SHALL stay stable while valid_out=1 and ready_in=0.
REQ-023 Inputs presented while ready_out=0 SHALL be ignored; no operation SHALL be lost or duplicated.
REQ-024 STAGES=1 SHALL degenerate to a single registered full-width adder with latency 1.

Reset
REQ-025 While rst_in=1, all valid bits, S_out, C_out and all stage data SHALL be 0; ready_out SHALL be 1.
REQ-026 Asserting rst_in mid-operation SHALL discard all in-flight operations; no result SHALL emerge after release.
REQ-027 The first transfer SHALL be accepted on the first rising edge after rst_in deasserts.

Configuration
REQ-028 Macro PIPELINED_ADDER_OVERFLOW_EN SHALL control the signed-overflow flag.
REQ-029 With the macro defined: output V_out  1  two's-complement overflow = carry into MSB XOR carry out of MSB, pipelined with S_out and reset to 0.
REQ-030 Without the macro: the V_out port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=32, STAGES=4, ready_in=1 unless stated)
REQ-031 A=15, B=49, C_in=1, one transfer -> S_out=65, C_out=0, with valid_out=1 exactly 4 cycles later for one cycle.
REQ-032 A=32'hFFFFFFFF, B=0, C_in=1 -> S_out=0, C_out=1 (full carry ripple across all 4 stages).
REQ-033 Back-to-back transfers (1+2), (3+4), (5+6) -> results 3, 7, 11 on consecutive cycles 4-6 after the first.
REQ-034 ready_in=0 for 3 cycles while the result 65 is valid -> S_out holds 65, ready_out=0, a pending input is not accepted, and the stream resumes in order once ready_in=1.
REQ-035 rst_in pulsed 2 cycles after accepting 15+49 -> valid_out stays 0 for 10 cycles and all outputs are 0.
REQ-036 With PIPELINED_ADDER_OVERFLOW_EN: A=32'h7FFFFFFF, B=1 -> S_out=32'h80000000, V_out=1, C_out=0; A=B=32'h80000000 -> S_out=0, V_out=1, C_out=1.
